// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the per-frame game-logic sequencer.
//   sched_state_t : frame sequencer FSM state encoding
//   PH_*          : fixed phase order of the object-update blocks within a frame
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } sched_state_t;

    localparam int unsigned PH_PHYS  = 0;
    localparam int unsigned PH_PIPE  = 1;
    localparam int unsigned PH_COLL  = 2;
    localparam int unsigned PH_SCORE = 3;

endpackage

// File: rtl/frame_sched_rise_detect.sv
// rise_detect: turns a clk_100MHz-synchronous level into a 1-cycle pulse on
// each rising edge.
//   clk_100MHz : system clock
//   reset      : synchronous, active-high; clears the history register
//   level      : input level (already synchronous to clk_100MHz)
//   pulse      : high for the one cycle in which level is 1 and was 0
module rise_detect (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    // History cleared by reset, so a level already high at release yields one pulse.
    assign pulse = level & ~level_q;

endmodule

// File: rtl/frame_sched.sv
// frame_sched: per-frame update sequencer for the game logic.
// Detects clk_60Hz / clk_5Hz rising edges, and once per 60 Hz frame walks the
// update blocks through N_PHASE phases with a start/done handshake.
//   clk_100MHz  : system clock (only clock)
//   reset       : synchronous, active-high
//   clk_60Hz    : 60 Hz frame level; rising edge launches a frame while run=1
//   clk_5Hz     : 5 Hz animation level; rising edge gives anim_tick while run=1
//   run         : frames are launched only while high
//   clear_err   : clears overrun_cnt and err_timeout (wins over same-cycle set)
//   phase_done  : one-hot done from each update block; only bit idx is honoured
//   phase_start : one-hot 1-cycle start to each update block
//   cur_phase   : active phase index, 0 when idle
//   busy        : frame in progress
//   frame_done  : 1-cycle pulse after the last phase completes
//   anim_tick   : 1-cycle pulse, one cycle after a clk_5Hz rise with run=1
//   overrun_cnt : saturating count of frame ticks dropped while busy
//   err_timeout : sticky; a phase waited TIMEOUT cycles without done
module frame_sched
    import game_pkg::*;
#(
    parameter int unsigned N_PHASE = 4,
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned OVR_W   = 8
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               clk_60Hz,
    input  logic               clk_5Hz,
    input  logic               run,
    input  logic               clear_err,
    input  logic [N_PHASE-1:0] phase_done,
    output logic [N_PHASE-1:0] phase_start,
    output logic [2:0]         cur_phase,
    output logic               busy,
    output logic               frame_done,
    output logic               anim_tick,
    output logic [OVR_W-1:0]   overrun_cnt,
    output logic               err_timeout
);

    localparam int unsigned IDX_W = $clog2(N_PHASE);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_PHASE - 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT - 1);

    logic frame_tick;
    logic a2_tick;

    rise_detect u_rise_60 (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .level      (clk_60Hz),
        .pulse      (frame_tick)
    );

    rise_detect u_rise_5 (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .level      (clk_5Hz),
        .pulse      (a2_tick)
    );

    sched_state_t     state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [TMR_W-1:0] timer, timer_next;
    logic             done_next;
    logic             timeout_hit;
    logic             ovr_inc;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            timer <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        timer_next  = timer + TMR_W'(1);
        done_next   = 1'b0;
        timeout_hit = 1'b0;
        phase_start = '0;
        cur_phase   = '0;
        busy        = 1'b0;

        case (state)
            IDLE: begin
                timer_next = '0;
                if (frame_tick && run) begin
                    idx_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                phase_start = N_PHASE'(1) << idx;
                cur_phase   = 3'(idx);
                busy        = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                cur_phase = 3'(idx);
                busy      = 1'b1;
                if (phase_done[idx]) begin
                    if (idx == LAST_IDX) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx + IDX_W'(1);
                        timer_next = '0;
                        state_next = START;
                    end
                end else if (timer == TMR_LIMIT) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The timer is zeroed on entry to START and counts through START and WAIT,
    // so the timeout fires TIMEOUT cycles after the phase_start pulse.

    // Any frame tick outside IDLE is dropped, including the acceptance cycle
    // of the last done (state is still WAIT then).
    assign ovr_inc = frame_tick && (state != IDLE);

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            frame_done  <= 1'b0;
            anim_tick   <= 1'b0;
            overrun_cnt <= '0;
            err_timeout <= 1'b0;
        end else begin
            frame_done <= done_next;
            anim_tick  <= a2_tick & run;
            if (clear_err) begin
                overrun_cnt <= '0;
                err_timeout <= 1'b0;
            end else begin
                if (ovr_inc && (overrun_cnt != '1)) begin
                    overrun_cnt <= overrun_cnt + OVR_W'(1);
                end
                if (timeout_hit) begin
                    err_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_sched.sv
`timescale 1ns / 1ps
// tb_frame_sched: self-checking bench for frame_sched (N_PHASE=4, TIMEOUT=16).
// Phase start/frame_done events are scored against a queue of expected events;
// an auto-responder answers done 3 cycles after each enabled phase start.
module tb_frame_sched;
    import game_pkg::*;

    localparam int unsigned NP = 4;

    logic          clk_100MHz;
    logic          reset;
    logic          clk_60Hz;
    logic          clk_5Hz;
    logic          run;
    logic          clear_err;
    logic [NP-1:0] phase_done;
    logic [NP-1:0] phase_start;
    logic [2:0]    cur_phase;
    logic          busy;
    logic          frame_done;
    logic          anim_tick;
    logic [7:0]    overrun_cnt;
    logic          err_timeout;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic [NP-1:0] resp_mask;
    logic [NP:0]   sb[$];

    typedef struct {
        logic run;
        logic c5;
        logic exp_anim;
    } anim_vec_t;

    anim_vec_t tbl[8];

    frame_sched #(
        .N_PHASE (NP),
        .TIMEOUT (16),
        .OVR_W   (8)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .clk_60Hz    (clk_60Hz),
        .clk_5Hz     (clk_5Hz),
        .run         (run),
        .clear_err   (clear_err),
        .phase_done  (phase_done),
        .phase_start (phase_start),
        .cur_phase   (cur_phase),
        .busy        (busy),
        .frame_done  (frame_done),
        .anim_tick   (anim_tick),
        .overrun_cnt (overrun_cnt),
        .err_timeout (err_timeout)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected events: one per phase start, then frame_done if the frame completes.
    task automatic push_frame(input int n_ph, input bit with_done);
        for (int i = 0; i < n_ph; i++) sb.push_back({1'b0, NP'(1) << i});
        if (with_done) sb.push_back({1'b1, {NP{1'b0}}});
    endtask

    task automatic pulse60();
        clk_60Hz = 1'b1;
        @(negedge clk_100MHz);
        clk_60Hz = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clk_100MHz);
        clear_err = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit hit = 1'b0;
        for (int i = 0; i < max_cyc && !hit; i++) begin
            @(negedge clk_100MHz);
            #1;
            if (sb.size() == 0 && !busy) hit = 1'b1;
        end
        check("wait_idle", int'(hit), 1);
    endtask

    task automatic wait_phase(input int ph, input bit want_start);
        bit hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk_100MHz);
            #1;
            if (busy && cur_phase == 3'(ph) && ((phase_start != '0) == want_start)) hit = 1'b1;
        end
        check($sformatf("wait_phase%0d", ph), int'(hit), 1);
    endtask

    // Scoreboard monitor: every start pulse or frame_done must match the queue head.
    initial begin
        logic [NP:0] act;
        logic [NP:0] exp;
        forever begin
            @(negedge clk_100MHz);
            if (!reset && (phase_start != '0 || frame_done)) begin
                act = {frame_done, phase_start};
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %0h expected none at %0t", act, $time);
                end else begin
                    exp = sb.pop_front();
                    check("sb_event", int'(act), int'(exp));
                end
            end
        end
    end

    // Auto-responder: done arrives in the 3rd WAIT cycle after an enabled start.
    initial begin
        logic [NP-1:0] bits;
        @(negedge clk_100MHz);
        forever begin
            if (!reset && (phase_start & resp_mask) != '0) begin
                bits = phase_start;
                repeat (3) @(negedge clk_100MHz);
                phase_done = bits;
                @(negedge clk_100MHz);
                phase_done = '0;
            end else begin
                @(negedge clk_100MHz);
            end
        end
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b0};

        reset = 1'b1; run = 1'b0; clear_err = 1'b0;
        clk_60Hz = 1'b0; clk_5Hz = 1'b0; phase_done = '0; resp_mask = '0;
        repeat (3) @(negedge clk_100MHz);
        check("rst_phase_start", int'(phase_start), 0);
        check("rst_cur_phase",   int'(cur_phase),   0);
        check("rst_busy",        int'(busy),        0);
        check("rst_frame_done",  int'(frame_done),  0);
        check("rst_anim_tick",   int'(anim_tick),   0);
        check("rst_overrun",     int'(overrun_cnt), 0);
        check("rst_err_timeout", int'(err_timeout), 0);
        reset = 1'b0; run = 1'b1; resp_mask = '1;
        @(negedge clk_100MHz);

        // 1: clean frame, plus an anim tick while busy
        push_frame(NP, 1'b1);
        pulse60();
        repeat (4) @(negedge clk_100MHz);
        clk_5Hz = 1'b1;
        @(negedge clk_100MHz);
        check("anim_midframe", int'(anim_tick), 1);
        check("busy_midframe", int'(busy), 1);
        clk_5Hz = 1'b0;
        @(negedge clk_100MHz);
        check("anim_one_cycle", int'(anim_tick), 0);
        wait_idle(100);
        @(negedge clk_100MHz);
        check("t1_busy_after", int'(busy), 0);
        check("t1_frame_done_pulse", int'(frame_done), 0);

        // 2: tick during WAIT of phase 1 is dropped and counted
        push_frame(NP, 1'b1);
        pulse60();
        wait_phase(1, 1'b0);
        pulse60();
        check("ovr_single", int'(overrun_cnt), 1);
        wait_idle(100);
        pulse_clear();
        check("ovr_cleared", int'(overrun_cnt), 0);

        // tick on the same edge the last done is accepted is still dropped
        push_frame(NP, 1'b1);
        pulse60();
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge clk_100MHz);
                #1;
                if (phase_done[PH_SCORE]) hit = 1'b1;
            end
            check("wait_last_done", int'(hit), 1);
        end
        pulse60();
        check("ovr_at_accept", int'(overrun_cnt), 1);
        wait_idle(100);
        repeat (3) @(negedge clk_100MHz);
        check("no_restart_after_accept", int'(busy), 0);

        // 300 more dropped ticks: 6 per frame over 50 frames -> saturate
        for (int f = 0; f < 50; f++) begin
            push_frame(NP, 1'b1);
            pulse60();
            for (int k = 0; k < 6; k++) begin
                @(negedge clk_100MHz);
                clk_60Hz = 1'b1;
                @(negedge clk_100MHz);
                clk_60Hz = 1'b0;
            end
            wait_idle(100);
            if (f == 9) check("ovr_count_61", int'(overrun_cnt), 61);
        end
        check("ovr_saturated", int'(overrun_cnt), 255);
        pulse_clear();
        check("ovr_clear_sat", int'(overrun_cnt), 0);

        // 3: phase 2 hangs -> timeout 16 cycles after its start
        resp_mask = 4'b1111 & ~(4'b0001 << PH_COLL);
        push_frame(3, 1'b0);
        pulse60();
        wait_phase(PH_COLL, 1'b1);
        repeat (15) @(negedge clk_100MHz);
        check("tmo_not_yet", int'(err_timeout), 0);
        check("tmo_busy_before", int'(busy), 1);
        @(negedge clk_100MHz);
        check("tmo_set", int'(err_timeout), 1);
        check("tmo_idle", int'(busy), 0);
        check("tmo_no_frame_done", int'(frame_done), 0);
        resp_mask = '1;
        wait_idle(20);
        push_frame(NP, 1'b1);
        pulse60();
        wait_idle(100);
        check("tmo_sticky", int'(err_timeout), 1);
        pulse_clear();
        check("tmo_cleared", int'(err_timeout), 0);

        // 4: run dropped mid-frame -> frame completes; next tick ignored
        push_frame(NP, 1'b1);
        pulse60();
        wait_phase(1, 1'b0);
        run = 1'b0;
        wait_idle(100);
        pulse60();
        repeat (5) @(negedge clk_100MHz);
        check("run0_no_start", int'(busy), 0);
        check("run0_no_overrun", int'(overrun_cnt), 0);

        // 5: anim_tick table
        for (int i = 0; i < 8; i++) begin
            run = tbl[i].run;
            clk_5Hz = tbl[i].c5;
            @(negedge clk_100MHz);
            check($sformatf("anim_vec%0d", i), int'(anim_tick), int'(tbl[i].exp_anim));
        end

        // 6: reset in WAIT of phase 2; late done ignored
        run = 1'b1;
        resp_mask = 4'b1111 & ~(4'b0001 << PH_COLL);
        push_frame(3, 1'b0);
        pulse60();
        wait_phase(PH_COLL, 1'b1);
        @(negedge clk_100MHz);
        check("t6_in_wait", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk_100MHz);
        check("t6_phase_start", int'(phase_start), 0);
        check("t6_cur_phase",   int'(cur_phase),   0);
        check("t6_busy",        int'(busy),        0);
        check("t6_frame_done",  int'(frame_done),  0);
        check("t6_anim",        int'(anim_tick),   0);
        reset = 1'b0;
        phase_done = 4'b0001 << PH_COLL;
        @(negedge clk_100MHz);
        phase_done = '0;
        repeat (20) @(negedge clk_100MHz);
        check("t6_stay_idle", int'(busy), 0);
        check("t6_no_timeout", int'(err_timeout), 0);
        check("t6_no_frame_done", int'(frame_done), 0);
        check("sb_drained", int'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
